// File: rtl/machine_mode_types_1_12_pkg.sv
// rtl/machine_mode_types_1_12_pkg.sv - machine-mode CSR addresses, field layouts, WARL masks and reset constants
package machine_mode_types_1_12_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_MVENDORID = 12'hF11,
    CSR_MARCHID   = 12'hF12,
    CSR_MIMPID    = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } csr_addr_t;

  typedef struct packed {
    logic [18:0] rsvd_31_13;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_10_8;
    logic        mpie;
    logic [2:0]  rsvd_6_4;
    logic        mie;
    logic [2:0]  rsvd_2_0;
  } mstatus_t;

  typedef struct packed {
    logic [19:0] rsvd_31_12;
    logic        meie;
    logic [2:0]  rsvd_10_8;
    logic        mtie;
    logic [2:0]  rsvd_6_4;
    logic        msie;
    logic [2:0]  rsvd_2_0;
  } mie_t;

  typedef struct packed {
    logic [19:0] rsvd_31_12;
    logic        meip;
    logic [2:0]  rsvd_10_8;
    logic        mtip;
    logic [2:0]  rsvd_6_4;
    logic        msip;
    logic [2:0]  rsvd_2_0;
  } mip_t;

  typedef struct packed {
    logic        interrupt;
    logic [30:0] code;
  } mcause_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  localparam logic [31:0] MSTATUS_WMASK       = 32'h0000_1888;  // MPP, MPIE, MIE
  localparam logic [31:0] MIE_WMASK           = 32'h0000_0888;  // MEIE, MTIE, MSIE
  localparam logic [31:0] MSTATUS_RESET       = 32'h0000_1800;  // MPP = M
  localparam logic [31:0] MTVEC_RESET_DEFAULT = 32'h0000_0200;
  localparam logic [31:0] MISA_DEFAULT        = 32'h4000_0100;

  // Combine the CSR instruction operand with the current value
  function automatic logic [31:0] csr_apply(input logic wr, input logic set, input logic clr,
                                            input logic [31:0] old_v, input logic [31:0] new_v);
    if (wr)       return new_v;
    else if (set) return old_v | new_v;
    else if (clr) return old_v & ~new_v;
    else          return old_v;
  endfunction

endpackage

// File: rtl/priv_1_12_counter64.sv
// rtl/priv_1_12_counter64.sv - 64-bit counter with increment enable and per-half software write
module priv_1_12_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_q, count_d;

  // A software write freezes the counter for that cycle so the written value is what reads back
  always_comb begin
    count_d = count_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) count_d[31:0]  = wdata;
      if (wr_hi) count_d[63:32] = wdata;
    end else if (inc_en) begin
      count_d = count_q + 64'd1;
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/priv_1_12_csr_file.sv
// rtl/priv_1_12_csr_file.sv - machine-mode CSR file with trap CSRs, hardware inject and 64-bit counters
module priv_1_12_csr_file
  import machine_mode_types_1_12_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEFAULT,
  parameter logic [31:0] MISA_VALUE  = MISA_DEFAULT,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  curr_privilege_level,
  input  logic        csr_write,
  input  logic        csr_set,
  input  logic        csr_clear,
  input  logic        csr_read_only,
  input  logic        valid_write,
  input  logic [31:0] new_csr_val,
  input  logic        inst_ret,
  input  logic        inject_mcause,
  input  logic        inject_mepc,
  input  logic        inject_mip,
  input  logic        inject_mstatus,
  input  logic        inject_mtval,
  input  logic [31:0] next_mcause,
  input  logic [31:0] next_mepc,
  input  logic [31:0] next_mie,
  input  logic [31:0] next_mip,
  input  logic [31:0] next_mstatus,
  input  logic [31:0] next_mtval,
  output logic [31:0] old_csr_val,
  output logic        invalid_csr,
  output logic [31:0] curr_mcause,
  output logic [31:0] curr_mepc,
  output logic [31:0] curr_mie,
  output logic [31:0] curr_mip,
  output logic [31:0] curr_mstatus,
  output logic [31:0] curr_mtvec
);

  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;
  logic [63:0] mcycle, minstret;
  logic        implemented, op_present, commit;
  logic [31:0] wval;
  mstatus_t    ms_w;
  mtvec_t      tv_w;

  // Read mux; unimplemented addresses read zero and flag the access
  always_comb begin
    old_csr_val = '0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   old_csr_val = mstatus_q;
      CSR_MISA:      old_csr_val = MISA_VALUE;
      CSR_MIE:       old_csr_val = mie_q;
      CSR_MTVEC:     old_csr_val = mtvec_q;
      CSR_MSCRATCH:  old_csr_val = mscratch_q;
      CSR_MEPC:      old_csr_val = mepc_q;
      CSR_MCAUSE:    old_csr_val = mcause_q;
      CSR_MTVAL:     old_csr_val = mtval_q;
      CSR_MIP:       old_csr_val = mip_q;
      CSR_MCYCLE:    old_csr_val = mcycle[31:0];
      CSR_MCYCLEH:   old_csr_val = mcycle[63:32];
      CSR_MINSTRET:  old_csr_val = minstret[31:0];
      CSR_MINSTRETH: old_csr_val = minstret[63:32];
      CSR_MVENDORID: old_csr_val = '0;
      CSR_MARCHID:   old_csr_val = '0;
      CSR_MIMPID:    old_csr_val = '0;
      CSR_MHARTID:   old_csr_val = HART_ID;
      default:       implemented = 1'b0;
    endcase
  end

  assign op_present  = csr_write | csr_set | csr_clear;
  assign invalid_csr = !implemented
                    || (csr_addr[9:8] > curr_privilege_level)
                    || ((csr_addr[11:10] == 2'b11) && op_present && !csr_read_only);
  assign commit      = valid_write && op_present && !invalid_csr && !csr_read_only;
  assign wval        = csr_apply(csr_write, csr_set, csr_clear, old_csr_val, new_csr_val);

  // Next-state: software write with WARL filtering first, hardware inject overrides afterwards
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = mip_q;
    ms_w       = mstatus_t'((mstatus_q & ~MSTATUS_WMASK) | (wval & MSTATUS_WMASK));
    tv_w       = mtvec_t'(wval);
    if (ms_w.mpp == 2'b10) ms_w.mpp = mstatus_q[12:11];
    if (commit) begin
      case (csr_addr)
        CSR_MSTATUS:  mstatus_d  = ms_w;
        CSR_MIE:      mie_d      = (mie_q & ~MIE_WMASK) | (wval & MIE_WMASK);
        CSR_MTVEC:    if (tv_w.mode < 2'd2) mtvec_d = wval;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default:      ;
      endcase
    end
    if (inject_mstatus) begin
      mstatus_d = next_mstatus;
      mie_d     = next_mie;
    end
    if (inject_mepc)   mepc_d   = {next_mepc[31:2], 2'b00};
    if (inject_mcause) mcause_d = next_mcause;
    if (inject_mtval)  mtval_d  = next_mtval;
    if (inject_mip)    mip_d    = next_mip;
  end

  // CSR state registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mstatus_q  <= MSTATUS_RESET;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
    end
  end

  priv_1_12_counter64 u_mcycle (
    .clk    (CLK),
    .rst_n  (nRST),
    .inc_en (1'b1),
    .wr_lo  (commit && (csr_addr == CSR_MCYCLE)),
    .wr_hi  (commit && (csr_addr == CSR_MCYCLEH)),
    .wdata  (wval),
    .count  (mcycle)
  );

  priv_1_12_counter64 u_minstret (
    .clk    (CLK),
    .rst_n  (nRST),
    .inc_en (inst_ret),
    .wr_lo  (commit && (csr_addr == CSR_MINSTRET)),
    .wr_hi  (commit && (csr_addr == CSR_MINSTRETH)),
    .wdata  (wval),
    .count  (minstret)
  );

  assign curr_mcause  = mcause_q;
  assign curr_mepc    = mepc_q;
  assign curr_mie     = mie_q;
  assign curr_mip     = mip_q;
  assign curr_mstatus = mstatus_q;
  assign curr_mtvec   = mtvec_q;

endmodule
